// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin share of one combinational ALU/ALUdec between
// the integer execute path (0) and the address/branch-target path (1).
module alu_arbiter #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic [6:0]            req0_opcode,
  input  logic [2:0]            req0_funct,
  input  logic                  req0_add_rshift_type,
  input  logic [DATA_WIDTH-1:0] req0_A,
  input  logic [DATA_WIDTH-1:0] req0_B,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic [6:0]            req1_opcode,
  input  logic [2:0]            req1_funct,
  input  logic                  req1_add_rshift_type,
  input  logic [DATA_WIDTH-1:0] req1_A,
  input  logic [DATA_WIDTH-1:0] req1_B,
  output logic                  resp0_valid,
  input  logic                  resp0_ready,
  output logic [DATA_WIDTH-1:0] resp0_data,
  output logic                  resp1_valid,
  input  logic                  resp1_ready,
  output logic [DATA_WIDTH-1:0] resp1_data,
  output logic [6:0]            alu_opcode,
  output logic [2:0]            alu_funct,
  output logic                  alu_add_rshift_type,
  output logic [DATA_WIDTH-1:0] alu_A,
  output logic [DATA_WIDTH-1:0] alu_B,
  input  logic [DATA_WIDTH-1:0] alu_out
);

  logic                  elig0, elig1;
  logic                  grant0, grant1;
  logic                  prio_q, prio_d;
  logic                  resp0_valid_q, resp0_valid_d;
  logic                  resp1_valid_q, resp1_valid_d;
  logic [DATA_WIDTH-1:0] resp0_data_q, resp0_data_d;
  logic [DATA_WIDTH-1:0] resp1_data_q, resp1_data_d;

  // Grants see only handshake state, never operands or alu_out.
  always_comb begin
    elig0  = ~reset & req0_valid
           & (~resp0_valid_q | resp0_ready);
    elig1  = ~reset & req1_valid
           & (~resp1_valid_q | resp1_ready);
    grant0 = elig0 & (~elig1 | ~prio_q);
    grant1 = elig1 & (~elig0 | prio_q);
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;

  always_comb begin
    alu_opcode          = '0;
    alu_funct           = '0;
    alu_add_rshift_type = 1'b0;
    alu_A               = '0;
    alu_B               = '0;
    unique case (1'b1)
      grant0: begin
        alu_opcode          = req0_opcode;
        alu_funct           = req0_funct;
        alu_add_rshift_type = req0_add_rshift_type;
        alu_A               = req0_A;
        alu_B               = req0_B;
      end
      grant1: begin
        alu_opcode          = req1_opcode;
        alu_funct           = req1_funct;
        alu_add_rshift_type = req1_add_rshift_type;
        alu_A               = req1_A;
        alu_B               = req1_B;
      end
      default: ;
    endcase
  end

  // A new grant wins over a same-cycle drain, so the slot never bubbles.
  always_comb begin
    resp0_valid_d = resp0_valid_q;
    resp0_data_d  = resp0_data_q;
    resp1_valid_d = resp1_valid_q;
    resp1_data_d  = resp1_data_q;
    prio_d        = prio_q;
    if (grant0) begin
      resp0_valid_d = 1'b1;
      resp0_data_d  = alu_out;
      prio_d        = 1'b1;
    end else if (resp0_ready) begin
      resp0_valid_d = 1'b0;
    end
    if (grant1) begin
      resp1_valid_d = 1'b1;
      resp1_data_d  = alu_out;
      prio_d        = 1'b0;
    end else if (resp1_ready) begin
      resp1_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prio_q        <= 1'b0;
      resp0_valid_q <= 1'b0;
      resp1_valid_q <= 1'b0;
      resp0_data_q  <= '0;
      resp1_data_q  <= '0;
    end else begin
      prio_q        <= prio_d;
      resp0_valid_q <= resp0_valid_d;
      resp1_valid_q <= resp1_valid_d;
      resp0_data_q  <= resp0_data_d;
      resp1_data_q  <= resp1_data_d;
    end
  end

  assign resp0_valid = resp0_valid_q;
  assign resp1_valid = resp1_valid_q;
  assign resp0_data  = resp0_data_q;
  assign resp1_data  = resp1_data_q;

endmodule
